// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the 4:1 mux arbiter.
// The arbiter takes the slave side; the requester side (or bench) takes master.
interface mux4_rr_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       EN;
    logic       S0;
    logic       S1;
    logic       BUSY;

    modport slave  (input  REQ, output GNT, EN, S0, S1, BUSY);
    modport master (output REQ, input  GNT, EN, S0, S1, BUSY);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux (EN, S1:S0) with a one-hot grant.
// An owner keeps the mux for at most MAX_HOLD cycles while someone else waits;
// every handover passes through a one-cycle GAP with the mux disabled.
// Optional feature: define MUX4_ARB_PRIO0_EN to make REQ[0] strict-priority.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    mux4_rr_arbiter_if.slave    arb
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_sel;
    logic [7:0]  r_cnt;
    logic        r_en;
    logic [3:0]  r_gnt;

    logic        w_any;
    logic        w_others;
    logic        w_release;
    logic [1:0]  w_pick;

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Winner selection and release conditions for the current owner.
    always_comb begin
        w_any    = |arb.REQ;
        w_others = |(arb.REQ & ~r_gnt);
        w_pick   = rr_pick(arb.REQ, r_ptr);
`ifdef MUX4_ARB_PRIO0_EN
        if (arb.REQ[0]) w_pick = 2'd0;
        w_release = !arb.REQ[r_sel] ||
                    ((r_cnt == 8'(MAX_HOLD)) && w_others) ||
                    ((r_sel != 2'd0) && arb.REQ[0]);
`else
        w_release = !arb.REQ[r_sel] ||
                    ((r_cnt == 8'(MAX_HOLD)) && w_others);
`endif
    end

    // Arbiter FSM; all mux-facing outputs are registered here.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_cnt   <= 8'd0;
            r_en    <= 1'b0;
            r_gnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE, GAP: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_sel   <= w_pick;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_en    <= 1'b1;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_gnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        // Next search starts just past the releasing owner.
                        r_state <= GAP;
                        r_ptr   <= r_sel + 2'd1;
                        r_en    <= 1'b0;
                        r_gnt   <= 4'd0;
                    end else if (r_cnt != 8'(MAX_HOLD)) begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_gnt   <= 4'd0;
                end
            endcase
        end
    end

    assign arb.GNT  = r_gnt;
    assign arb.EN   = r_en;
    assign arb.S0   = r_sel[0];
    assign arb.S1   = r_sel[1];
    assign arb.BUSY = (r_state == GRANT);

endmodule
